// File: rtl/mips_fetch_decode_exec.sv
// Multi-cycle MIPS front end: fetch, decode/register-read and ALU execute.
// One instruction is in flight at a time. The ALU result is handed downstream
// with a one-cycle ex_valid token, and the next fetch waits for wb_done.
module mips_fetch_decode_exec #(
  parameter int IMEM_DEPTH = 16,
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32
) (
  input  logic                          clock,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          wb_en,
  input  logic [4:0]                    wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          wb_done,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [31:0]                   instruction,
  output logic [5:0]                    opcode,
  output logic [5:0]                    funct,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    rd,
  output logic [4:0]                    shamt,
  output logic [DATA_W-1:0]             immediate,
  output logic [DATA_W-1:0]             read_data1,
  output logic [DATA_W-1:0]             read_data2,
  output logic                          reg_dest,
  output logic                          branch,
  output logic                          mem_read,
  output logic                          mem_to_reg,
  output logic                          mem_write,
  output logic                          alu_src,
  output logic                          reg_write,
  output logic                          end_program,
  output logic [1:0]                    alu_op,
  output logic [DATA_W-1:0]             alu_out,
  output logic                          zero,
  output logic                          ex_valid,
  output logic                          halted
);
  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT} state_t;

  state_t            state_r, state_nxt_s;
  logic [31:0]       imem_r [IMEM_DEPTH];
  logic [DATA_W-1:0] regs_r [NREGS];

  logic [4:0]        dec_rs_s, dec_rt_s;
  logic [DATA_W-1:0] rd1_s, rd2_s, b_s, alu_s;
  logic              c_reg_dest_s, c_branch_s, c_mem_read_s, c_mem_to_reg_s;
  logic              c_mem_write_s, c_alu_src_s, c_reg_write_s, c_end_s;
  logic [1:0]        c_alu_op_s;

  // Program load port; contents survive reset.
  always_ff @(posedge clock) begin
    if (imem_we) begin
      imem_r[imem_addr] <= imem_wdata;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (start) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; wb_done is only meaningful while waiting.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH:  state_nxt_s = S_DECODE;
      S_DECODE: state_nxt_s = S_EXEC;
      S_EXEC:   state_nxt_s = end_program ? S_HALT : S_WAIT;
      S_WAIT:   begin
        if (wb_done) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_HALT:   state_nxt_s = S_HALT;
      default:  state_nxt_s = S_FETCH;
    endcase
  end

  // Control decode from the latched opcode.
  always_comb begin
    c_reg_dest_s   = 1'b0;
    c_branch_s     = 1'b0;
    c_mem_read_s   = 1'b0;
    c_mem_to_reg_s = 1'b0;
    c_mem_write_s  = 1'b0;
    c_alu_src_s    = 1'b0;
    c_reg_write_s  = 1'b0;
    c_end_s        = 1'b0;
    c_alu_op_s     = 2'b00;
    case (instruction[31:26])
      6'b000000: begin c_reg_dest_s = 1'b1; c_reg_write_s = 1'b1; c_alu_op_s = 2'b10; end
      6'b100011: begin
        c_alu_src_s = 1'b1; c_mem_to_reg_s = 1'b1; c_reg_write_s = 1'b1; c_mem_read_s = 1'b1;
      end
      6'b101011: begin c_alu_src_s = 1'b1; c_mem_write_s = 1'b1; end
      6'b000100: begin c_branch_s = 1'b1; c_alu_op_s = 2'b01; end
      6'b001000: begin c_alu_src_s = 1'b1; c_reg_write_s = 1'b1; end
      6'b111111: c_end_s = 1'b1;
      default:   c_end_s = 1'b0;
    endcase
  end

  // Register read with r0 hard-wired to zero and same-cycle writeBack bypass.
  always_comb begin
    dec_rs_s = instruction[25:21];
    dec_rt_s = instruction[20:16];
    if (dec_rs_s == 5'd0) begin
      rd1_s = {DATA_W{1'b0}};
    end else if (wb_en && (wb_addr == dec_rs_s)) begin
      rd1_s = wb_data;
    end else begin
      rd1_s = regs_r[dec_rs_s];
    end
    if (dec_rt_s == 5'd0) begin
      rd2_s = {DATA_W{1'b0}};
    end else if (wb_en && (wb_addr == dec_rt_s)) begin
      rd2_s = wb_data;
    end else begin
      rd2_s = regs_r[dec_rt_s];
    end
  end

  // ALU; all arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    b_s   = alu_src ? immediate : read_data2;
    alu_s = {DATA_W{1'b0}};
    case (alu_op)
      2'b00: alu_s = read_data1 + b_s;
      2'b01: alu_s = read_data1 - b_s;
      2'b10: begin
        case (funct)
          6'b100000: alu_s = read_data1 + b_s;
          6'b100010: alu_s = read_data1 - b_s;
          6'b100100: alu_s = read_data1 & b_s;
          6'b100101: alu_s = read_data1 | b_s;
          6'b101010: alu_s = {{(DATA_W-1){1'b0}}, ($signed(read_data1) < $signed(b_s))};
          6'b000000: alu_s = read_data2 << shamt;
          6'b000010: alu_s = read_data2 >> shamt;
          default:   alu_s = {DATA_W{1'b0}};
        endcase
      end
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  // Datapath registers: register file, pc and all stage outputs.
  always_ff @(posedge clock) begin
    if (start) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      pc <= {PC_W{1'b0}};
      instruction <= 32'd0;
      opcode <= 6'd0; funct <= 6'd0;
      rs <= 5'd0; rt <= 5'd0; rd <= 5'd0; shamt <= 5'd0;
      immediate <= {DATA_W{1'b0}};
      read_data1 <= {DATA_W{1'b0}};
      read_data2 <= {DATA_W{1'b0}};
      reg_dest <= 1'b0; branch <= 1'b0; mem_read <= 1'b0; mem_to_reg <= 1'b0;
      mem_write <= 1'b0; alu_src <= 1'b0; reg_write <= 1'b0; end_program <= 1'b0;
      alu_op <= 2'b00;
      alu_out <= {DATA_W{1'b0}};
      zero <= 1'b0; ex_valid <= 1'b0; halted <= 1'b0;
    end else begin
      if (wb_en && (wb_addr != 5'd0)) begin
        regs_r[wb_addr] <= wb_data;
      end
      case (state_r)
        S_FETCH: begin
          instruction <= imem_r[pc];
          pc <= pc + PC_ONE;
        end
        S_DECODE: begin
          opcode <= instruction[31:26];
          funct  <= instruction[5:0];
          rs     <= instruction[25:21];
          rt     <= instruction[20:16];
          rd     <= instruction[15:11];
          shamt  <= instruction[10:6];
          immediate  <= {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
          read_data1 <= rd1_s;
          read_data2 <= rd2_s;
          reg_dest <= c_reg_dest_s; branch <= c_branch_s; mem_read <= c_mem_read_s;
          mem_to_reg <= c_mem_to_reg_s; mem_write <= c_mem_write_s; alu_src <= c_alu_src_s;
          reg_write <= c_reg_write_s; end_program <= c_end_s; alu_op <= c_alu_op_s;
        end
        S_EXEC: begin
          if (end_program) begin
            halted <= 1'b1;
          end else begin
            alu_out  <= alu_s;
            zero     <= (alu_s == {DATA_W{1'b0}});
            ex_valid <= 1'b1;
            // Branch offset is added to the already-incremented pc.
            if (branch && (alu_s == {DATA_W{1'b0}})) begin
              pc <= pc + immediate[PC_W-1:0];
            end
          end
        end
        S_WAIT:  ex_valid <= 1'b0;
        default: ex_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_fetch_decode_exec.sv
// Directed testbench for mips_fetch_decode_exec.
module tb_mips_fetch_decode_exec;
  logic        clock = 1'b0;
  logic        start, imem_we, wb_en, wb_done;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata, wb_data;
  logic [4:0]  wb_addr;
  logic [3:0]  pc;
  logic [31:0] instruction, immediate, read_data1, read_data2, alu_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic        end_program, zero, ex_valid, halted;
  logic [1:0]  alu_op;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] prog [16];

  mips_fetch_decode_exec dut (
    .clock(clock), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_done(wb_done), .pc(pc), .instruction(instruction), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .immediate(immediate),
    .read_data1(read_data1), .read_data2(read_data2), .reg_dest(reg_dest),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .end_program(end_program), .alu_op(alu_op), .alu_out(alu_out), .zero(zero),
    .ex_valid(ex_valid), .halted(halted)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run3();
    tick(); tick(); tick();
  endtask

  task automatic release_wb();
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
  endtask

  initial begin
    start = 1'b1; imem_we = 1'b0; imem_addr = 4'd0; imem_wdata = 32'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_done = 1'b0;
    prog[0]  = 32'h20010005; // addi r1,r0,5
    prog[1]  = 32'h00221820; // add r3,r1,r2
    prog[2]  = 32'h00221824; // and r3,r1,r2
    prog[3]  = 32'h10000002; // beq r0,r0,+2
    prog[4]  = 32'hFC000000; // skipped by branch
    prog[5]  = 32'hFC000000; // skipped by branch
    prog[6]  = 32'h00221822; // sub r3,r1,r2
    prog[7]  = 32'h00221825; // or  r3,r1,r2
    prog[8]  = 32'h0022182A; // slt r3,r1,r2
    prog[9]  = 32'h00211822; // sub r3,r1,r1
    prog[10] = 32'h8C23FFFC; // lw r3,-4(r1)
    prog[11] = 32'h54000000; // unknown opcode 010101
    prog[12] = 32'h00021900; // sll r3,r2,4
    prog[13] = 32'h00011882; // srl r3,r1,2
    prog[14] = 32'h00000020; // add r0,r0,r0
    prog[15] = 32'h00000020; // add r0,r0,r0

    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_addr = 4'(i); imem_wdata = prog[i];
      tick();
    end
    imem_we = 1'b0;
    tick();
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_instruction", instruction, 32'd0);
    check("reset_alu_out", alu_out, 32'd0);
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_reg_write", 32'(reg_write), 32'd0);
    start = 1'b0;

    // addi r1,r0,5
    run3();
    check("addi_ex_valid", 32'(ex_valid), 32'd1);
    check("addi_alu_out", alu_out, 32'd5);
    check("addi_reg_write", 32'(reg_write), 32'd1);
    check("addi_alu_src", 32'(alu_src), 32'd1);
    check("addi_pc", 32'(pc), 32'd1);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    tick();
    check("ex_valid_one_cycle", 32'(ex_valid), 32'd0);
    check("wait_hold_alu_out", alu_out, 32'd5);
    wb_addr = 5'd2; wb_data = 32'd3;
    tick();
    wb_en = 1'b0;
    release_wb();

    // add / and
    run3();
    check("add_alu_out", alu_out, 32'd10);
    check("add_reg_dest", 32'(reg_dest), 32'd1);
    check("add_alu_op", 32'(alu_op), 32'd2);
    release_wb();
    run3();
    check("and_alu_out", alu_out, 32'd3);
    release_wb();

    // beq r0,r0,+2 at pc=3
    run3();
    check("beq_branch", 32'(branch), 32'd1);
    check("beq_zero", 32'(zero), 32'd1);
    check("beq_pc", 32'(pc), 32'd6);
    release_wb();

    // sub fetched from pc=6
    run3();
    check("sub_instruction", instruction, 32'h00221822);
    check("sub_alu_out", alu_out, 32'd4);
    check("sub_pc", 32'(pc), 32'd7);
    release_wb();
    run3();
    check("or_alu_out", alu_out, 32'd7);
    release_wb();
    run3();
    check("slt_alu_out", alu_out, 32'd0);
    release_wb();
    run3();
    check("sub_self_alu_out", alu_out, 32'd0);
    check("sub_self_zero", 32'(zero), 32'd1);
    release_wb();

    // lw r3,-4(r1) with r1=8 written in the decode cycle (bypass)
    tick();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd8;
    tick();
    wb_en = 1'b0;
    tick();
    check("lw_read_data1_bypass", read_data1, 32'd8);
    check("lw_immediate", immediate, 32'hFFFFFFFC);
    check("lw_alu_out", alu_out, 32'd4);
    check("lw_mem_read", 32'(mem_read), 32'd1);
    check("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("lw_reg_dest", 32'(reg_dest), 32'd0);
    release_wb();

    // unknown opcode, with wb_done driven during fetch/decode
    wb_done = 1'b1;
    tick(); tick();
    wb_done = 1'b0;
    tick();
    check("unk_ex_valid", 32'(ex_valid), 32'd1);
    check("unk_reg_write", 32'(reg_write), 32'd0);
    check("unk_alu_src", 32'(alu_src), 32'd0);
    check("unk_alu_op", 32'(alu_op), 32'd0);
    check("unk_branch", 32'(branch), 32'd0);
    tick(); tick();
    check("wait_hold_pc", 32'(pc), 32'd12);
    check("wait_hold_instruction", instruction, 32'h54000000);
    check("wait_no_ex_valid", 32'(ex_valid), 32'd0);
    release_wb();

    // shifts and the two trailing nops
    run3();
    check("sll_alu_out", alu_out, 32'h30);
    release_wb();
    run3();
    check("srl_alu_out", alu_out, 32'd2);
    release_wb();
    run3();
    check("nop14_pc", 32'(pc), 32'd15);
    release_wb();
    run3();
    check("wrap_pc", 32'(pc), 32'd0);
    imem_we = 1'b1; imem_addr = 4'd1; imem_wdata = 32'hFC000000;
    tick();
    imem_we = 1'b0;
    release_wb();

    // fetch at pc=0 while imem[0] is overwritten in the same cycle
    imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = 32'hFC000000;
    tick();
    imem_we = 1'b0;
    check("fetch_old_word", instruction, 32'h20010005);
    tick(); tick();
    check("rerun_addi_alu_out", alu_out, 32'd5);
    check("rerun_addi_pc", 32'(pc), 32'd1);
    release_wb();

    // halt instruction at pc=1
    run3();
    check("halt_no_ex_valid", 32'(ex_valid), 32'd0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_end_program", 32'(end_program), 32'd1);
    check("halt_pc", 32'(pc), 32'd2);
    release_wb();
    tick(); tick();
    check("halt_pc_frozen", 32'(pc), 32'd2);
    check("halt_stays", 32'(halted), 32'd1);

    // reset out of HALT, reloading imem[0] with add r3,r1,r2
    start = 1'b1; imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = 32'h00221820;
    tick();
    start = 1'b0; imem_we = 1'b0;
    check("rst_halt_halted", 32'(halted), 32'd0);
    check("rst_halt_pc", 32'(pc), 32'd0);

    // r1 written during fetch, r2 bypassed during decode
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    tick();
    wb_addr = 5'd2; wb_data = 32'd3;
    tick();
    wb_en = 1'b0;
    tick();
    check("rt_bypass_read_data2", read_data2, 32'd3);
    check("rt_bypass_alu_out", alu_out, 32'd10);

    // reset in the middle of WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_wait_pc", 32'(pc), 32'd0);
    check("rst_wait_alu_out", alu_out, 32'd0);
    check("rst_wait_instruction", instruction, 32'd0);
    check("rst_wait_reg_write", 32'(reg_write), 32'd0);
    run3();
    check("post_rst_ex_valid", 32'(ex_valid), 32'd1);
    check("post_rst_read_data1", read_data1, 32'd0);
    check("post_rst_read_data2", read_data2, 32'd0);
    check("post_rst_zero", 32'(zero), 32'd1);
    check("post_rst_pc", 32'(pc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
